// File: rtl/contador_mod7_updown_pkg.sv
// Shared constants for the mod-7 up/down counter and its JK flip-flop slice.
package contador_mod7_updown_pkg;
  localparam int unsigned CNT_W = 3;

  localparam logic [CNT_W-1:0] MOD7_MAX     = 3'd6;
  localparam logic [CNT_W-1:0] MOD7_MIN     = 3'd0;
  localparam logic [CNT_W-1:0] MOD7_ILLEGAL = 3'd7;

  typedef struct packed {
    logic [CNT_W-1:0] next;
    logic             illegal;
  } nxt_t;

  // Wrap-around step in either direction.
  function automatic logic [CNT_W-1:0] mod7_step(input logic [CNT_W-1:0] cur, input logic up);
    if (up) return (cur == MOD7_MAX) ? MOD7_MIN : cur + 3'd1;
    else    return (cur == MOD7_MIN) ? MOD7_MAX : cur - 3'd1;
  endfunction
endpackage

// File: rtl/contador_mod7_updown_ffjk_ar.sv
// JK flip-flop with asynchronous active-low reset; keeps Q and NQ as separate registers.
module ffjk_ar (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic nq
);
  logic state;
  logic state_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= 1'b0;
      state_n <= 1'b1;
    end else begin
      case ({j, k})
        2'b00:   begin state <= state;  state_n <= state_n; end
        2'b01:   begin state <= 1'b0;   state_n <= 1'b1;    end
        2'b10:   begin state <= 1'b1;   state_n <= 1'b0;    end
        default: begin state <= ~state; state_n <= state;   end
      endcase
    end
  end

  assign q  = state;
  assign nq = state_n;
endmodule

// File: rtl/contador_mod7_updown.sv
// Mod-7 up/down counter built from per-bit JK flip-flops, with load and illegal-value recovery.
module contador_mod7_updown
  import contador_mod7_updown_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [CNT_W-1:0] d,
  output logic [CNT_W-1:0] q,
  output logic [CNT_W-1:0] nq,
  output logic             tc,
  output logic             illegal
);
  nxt_t             nxt;
  logic [CNT_W-1:0] j;
  logic [CNT_W-1:0] k;

  // Priority: load, then recovery from the unreachable value 7, then count, then hold.
  always_comb begin
    nxt.next    = q;
    nxt.illegal = 1'b0;
    if (load) begin
      if (d == MOD7_ILLEGAL) begin
        nxt.next    = MOD7_MIN;
        nxt.illegal = 1'b1;
      end else begin
        nxt.next = d;
      end
    end else if (q == MOD7_ILLEGAL) begin
      nxt.next    = MOD7_MIN;
      nxt.illegal = 1'b1;
    end else if (en) begin
      nxt.next = mod7_step(q, up);
    end
  end

  // JK excitation: only drive a bit that actually has to change.
  assign j = nxt.next & ~q;
  assign k = ~nxt.next & q;

  for (genvar i = 0; i < CNT_W; i++) begin : g_bit
    ffjk_ar u_ff (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i]),
      .nq    (nq[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal <= 1'b0;
    else        illegal <= nxt.illegal;
  end

  assign tc = en & ~load & ((up & (q == MOD7_MAX)) | (~up & (q == MOD7_MIN)));
endmodule

// File: tb/tb_contador_mod7_updown.sv
// Directed bench for contador_mod7_updown: inputs change on negedge, outputs sampled on negedge.
module tb_contador_mod7_updown;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, load;
  logic [2:0] d;
  logic [2:0] q, nq;
  logic       tc, illegal;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;

  contador_mod7_updown dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .d(d),
    .q(q), .nq(nq), .tc(tc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // nq must mirror q in every sampled cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (nq !== ~q) begin
        errors++;
        $display("FAIL nq_mirror: q=%0d nq=%0d required nq=%0d", q, nq, 3'(~q));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    en = 1'b1; up = 1'b0; load = 1'b0; d = 3'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q !== 3'd0)       begin errors++; $display("FAIL reset_q: got %0d want 0", q); end
    checks++; if (nq !== 3'd7)      begin errors++; $display("FAIL reset_nq: got %0d want 7", nq); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    checks++; if (tc !== 1'b1)      begin errors++; $display("FAIL reset_tc_down: got %b want 1", tc); end
    tick;
    checks++; if (q !== 3'd0)       begin errors++; $display("FAIL reset_hold_q: got %0d want 0", q); end
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_count_up;
    logic [2:0] exp_q [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
    logic [2:0] cur = 3'd0;
    en = 1'b1; up = 1'b1; load = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tc !== (cur == 3'd6)) begin errors++; $display("FAIL up_tc[%0d]: q=%0d got %b want %b", i, cur, tc, cur == 3'd6); end
      tick;
      checks++;
      if (q !== exp_q[i]) begin errors++; $display("FAIL up_q[%0d]: got %0d want %0d", i, q, exp_q[i]); end
      cur = exp_q[i];
    end
  endtask

  task automatic test_load_down;
    logic [2:0] exp_q [4] = '{3'd1, 3'd0, 3'd6, 3'd5};
    logic [2:0] cur = 3'd2;
    load = 1'b1; d = 3'd2; en = 1'b0;
    #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL load_tc: got %b want 0", tc); end
    tick;
    checks++; if (q !== 3'd2) begin errors++; $display("FAIL load2_q: got %0d want 2", q); end
    load = 1'b0; en = 1'b1; up = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tc !== (cur == 3'd0)) begin errors++; $display("FAIL down_tc[%0d]: q=%0d got %b want %b", i, cur, tc, cur == 3'd0); end
      tick;
      checks++;
      if (q !== exp_q[i]) begin errors++; $display("FAIL down_q[%0d]: got %0d want %0d", i, q, exp_q[i]); end
      cur = exp_q[i];
    end
  endtask

  task automatic test_load_illegal;
    load = 1'b1; d = 3'd7; en = 1'b0;
    tick;
    checks++; if (q !== 3'd0)       begin errors++; $display("FAIL load7_q: got %0d want 0", q); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL load7_illegal: got %b want 1", illegal); end
    load = 1'b0;
    tick;
    checks++; if (q !== 3'd0)       begin errors++; $display("FAIL load7_hold_q: got %0d want 0", q); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL load7_clear: got %b want 0", illegal); end
  endtask

  task automatic test_load_priority;
    load = 1'b1; d = 3'd6; en = 1'b0;
    tick;
    checks++; if (q !== 3'd6) begin errors++; $display("FAIL load6_q: got %0d want 6", q); end
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL prio_tc_noload: got %b want 1", tc); end
    load = 1'b1; d = 3'd3;
    #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL prio_tc_load: got %b want 0", tc); end
    tick;
    checks++; if (q !== 3'd3)       begin errors++; $display("FAIL prio_q: got %0d want 3", q); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL prio_illegal: got %b want 0", illegal); end
  endtask

  task automatic test_direction;
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick;
    checks++; if (q !== 3'd4) begin errors++; $display("FAIL dir_up_q: got %0d want 4", q); end
    up = 1'b0;
    tick;
    checks++; if (q !== 3'd3) begin errors++; $display("FAIL dir_down_q: got %0d want 3", q); end
    up = 1'b1;
    tick;
    checks++; if (q !== 3'd4) begin errors++; $display("FAIL dir_up2_q: got %0d want 4", q); end
    en = 1'b0;
    tick;
    checks++; if (q !== 3'd4) begin errors++; $display("FAIL hold_q: got %0d want 4", q); end
  endtask

  task automatic test_async_reset;
    en = 1'b1; up = 1'b1; load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q !== 3'd0)       begin errors++; $display("FAIL async_q: got %0d want 0", q); end
    checks++; if (nq !== 3'd7)      begin errors++; $display("FAIL async_nq: got %0d want 7", nq); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL async_illegal: got %b want 0", illegal); end
    load = 1'b1; d = 3'd5;
    tick;
    checks++; if (q !== 3'd0) begin errors++; $display("FAIL async_override_q: got %0d want 0", q); end
    rst_n = 1'b1;
    tick;
    checks++; if (q !== 3'd5) begin errors++; $display("FAIL first_edge_q: got %0d want 5", q); end
  endtask

  task automatic test_force_illegal;
    load = 1'b0; en = 1'b0; up = 1'b1;
    #1;
    force dut.g_bit[0].u_ff.state = 1'b1; force dut.g_bit[0].u_ff.state_n = 1'b0;
    force dut.g_bit[1].u_ff.state = 1'b1; force dut.g_bit[1].u_ff.state_n = 1'b0;
    force dut.g_bit[2].u_ff.state = 1'b1; force dut.g_bit[2].u_ff.state_n = 1'b0;
    #1;
    release dut.g_bit[0].u_ff.state; release dut.g_bit[0].u_ff.state_n;
    release dut.g_bit[1].u_ff.state; release dut.g_bit[1].u_ff.state_n;
    release dut.g_bit[2].u_ff.state; release dut.g_bit[2].u_ff.state_n;
    #1;
    checks++; if (q !== 3'd7)  begin errors++; $display("FAIL forced_q: got %0d want 7", q); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL forced_tc: got %b want 0", tc); end
    tick;
    checks++; if (q !== 3'd0)       begin errors++; $display("FAIL recover_q: got %0d want 0", q); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL recover_illegal: got %b want 1", illegal); end
    tick;
    checks++; if (q !== 3'd0)       begin errors++; $display("FAIL recover_hold_q: got %0d want 0", q); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL recover_clear: got %b want 0", illegal); end
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_load_down;
    test_load_illegal;
    test_load_priority;
    test_direction;
    test_async_reset;
    test_force_illegal;
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/contador_mod7_updown.md
CONTADOR_MOD7_UPDOWN -- requirements
Module: contador_mod7_updown

Interface
REQ-001 The module SHALL have no parameters; the modulus and terminal values are fixed package constants.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  count enable.
REQ-005 up  input  1  direction: 1 = count up, 0 = count down.
REQ-006 load  input  1  synchronous parallel load request.
REQ-007 d  input  3  load value.
REQ-008 q  output  3  current count, registered.
REQ-009 nq  output  3  bitwise complement of q, registered.
REQ-010 tc  output  1  terminal count, combinational.
REQ-011 illegal  output  1  one-cycle registered flag for an out-of-range load or state.

Function
REQ-012 Legal count range SHALL be 0..6; the value 7 is illegal.
REQ-013 Priority at each rising clk edge SHALL be: load, then illegal-state recovery, then en, then hold.
REQ-014 For load=1 with d<=6, q SHALL take the value d on the next edge, with illegal<=0.
REQ-015 For load=1 with d==7, q SHALL take 0 on the next edge, with illegal<=1.
REQ-016 For load=0 with q==7 (fault), q SHALL take 0 on the next edge regardless of en, with illegal<=1.
REQ-017 For load=0, en=1, up=1: q SHALL go from 6 to 0; otherwise q SHALL go to q+1.
REQ-018 For load=0, en=1, up=0: q SHALL go from 0 to 6; otherwise q SHALL go to q-1.
REQ-019 For load=0 and en=0 with a legal q, q SHALL hold.
REQ-020 illegal SHALL be 0 on every edge not covered by REQ-015 and REQ-016.
REQ-021 nq SHALL equal ~q in every cycle, including reset.
REQ-022 tc SHALL equal en & ~load & ((up & q==6) | (~up & q==0)), so it is high exactly in the cycle before a wrap.
REQ-023 Direction changes SHALL take effect on the same edge with no extra latency.
REQ-024 Latency from load, en or up to q SHALL be exactly one clock edge.

Reset
REQ-025 When rst_n=0, asynchronously: q=0, nq=7, illegal=0; tc follows REQ-022 with q=0.
REQ-026 Reset SHALL override load and en at any point, including mid-count.
REQ-027 The first edge after rst_n deasserts SHALL be evaluated normally per REQ-013.

Structure
REQ-028 A shared package SHALL hold MOD7_MAX=3'd6, MOD7_MIN=3'd0 and MOD7_ILLEGAL=3'd7.
REQ-029 Each count bit SHALL be one instance of sub-module ffjk_ar.
REQ-030 ffjk_ar SHALL be a JK flip-flop with asynchronous active-low reset to Q=0/NQ=1, implementing hold, set, reset and toggle.
REQ-031 Top-level logic SHALL compute the next state, then derive J/K per bit by JK excitation: J=next & ~cur, K=~next & cur.
REQ-032 The illegal flag register SHALL live in the top module, not in ffjk_ar.

Verification
REQ-033 Reset, then en=1, up=1 for 8 cycles -> q sequence 1,2,3,4,5,6,0,1; tc=1 only while q=6.
REQ-034 Load d=2, then en=1, up=0 for 4 cycles -> q sequence 2,1,0,6,5; tc=1 only while q=0.
REQ-035 Load d=7 -> q=0 and illegal=1 for exactly one cycle; with en=0 afterwards, q stays 0 and illegal=0.
REQ-036 At q=6 with en=1, up=1 and load=1, d=3 on the same edge -> q=3 (load wins) and tc=0.
REQ-037 Assert rst_n=0 between clock edges mid-count at q=4 -> q=0 and nq=7 immediately, without waiting for a clock edge.
REQ-038 Force q=7 in simulation with en=0 -> next edge gives q=0 and illegal=1; throughout, nq==~q is checked every cycle.
